// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared external 8-bit ALU: grants one requester at a time,
// registers its operands onto the ALU, captures the op-selected result and returns it with valid/ready.
module alu_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake rule for both sides: a transfer happens on the rising edge where valid and
  // ready are both high; the sender keeps its payload stable until that edge.
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_flag,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [1:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_sum,
  input  logic                  alu_cout,
  input  logic [WIDTH-1:0]      alu_diff,
  input  logic                  alu_bout,
  input  logic [WIDTH-1:0]      alu_xor,
  input  logic [WIDTH-1:0]      alu_shl,
  output logic                  busy,
  output logic [15:0]           op_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_result_q, resp_result_d;
  logic              resp_flag_q, resp_flag_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [NREQ-1:0]   grant_oh;
  logic [ID_W:0]     scan_idx;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [1:0]        sel_op;
  logic              accept;
  logic              resp_done;

  // Scan starts just after the last winner so every requester is reached within NREQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = {1'b0, last_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NREQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NREQ);
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_found && (grant_id == ID_W'(i))) begin
        grant_oh[i] = 1'b1;
        sel_a       = req_a[i*WIDTH +: WIDTH];
        sel_b       = req_b[i*WIDTH +: WIDTH];
        sel_op      = req_op[i*2 +: 2];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE) ? grant_oh : '0;
  assign accept    = (state_q == S_IDLE) && grant_found;
  assign resp_done = (state_q == S_RESP) && resp_valid_q && resp_ready;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gid_d         = gid_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flag_d   = resp_flag_q;
    op_count_d    = op_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          last_d   = grant_id;
          gid_d    = grant_id;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // The external ALU has had a full cycle on the registered operands.
        unique case (alu_op_q)
          OP_ADD: begin
            resp_result_d = alu_sum;
            resp_flag_d   = alu_cout;
          end
          OP_SUB: begin
            resp_result_d = alu_diff;
            resp_flag_d   = alu_bout;
          end
          OP_XOR: begin
            resp_result_d = alu_xor;
            resp_flag_d   = 1'b0;
          end
          default: begin
            resp_result_d = alu_shl;
            resp_flag_d   = 1'b0;
          end
        endcase
        resp_id_d    = gid_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_done) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= ID_W'(NREQ-1);
      gid_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_flag_q   <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gid_q         <= gid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flag_q   <= resp_flag_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flag   = resp_flag_q;
  assign op_count    = op_count_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_result) && $stable(resp_id)
                                      && $stable(resp_flag)));
  a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_IDLE) |-> (req_ready == '0));

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural stand-in for the shared ALU.
module tb_alu_rr_scheduler;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic           resp_valid;
  logic           resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_flag;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_sum, alu_diff, alu_xor, alu_shl;
  logic           alu_cout, alu_bout;
  logic           busy;
  logic [15:0]    op_count;
  logic [1:0]     dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_count;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // external ALU
  assign {alu_cout, alu_sum}  = {1'b0, alu_a} + {1'b0, alu_b};
  assign {alu_bout, alu_diff} = {1'b0, alu_a} - {1'b0, alu_b};
  assign alu_xor              = alu_a ^ alu_b;
  assign alu_shl              = alu_a << alu_b[2:0];

  alu_rr_scheduler #(.WIDTH(W), .NREQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flag(resp_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_diff(alu_diff), .alu_bout(alu_bout),
    .alu_xor(alu_xor), .alu_shl(alu_shl),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; all of them leave time at 1ns after a rising edge
  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*2 +: 2] = op;
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] exp_res, input logic exp_flag);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    #1 chk("op_req_ready", 32'(req_ready), 32'(oh));
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    chk("op_exec_busy", 32'(busy), 32'd1);
    chk("op_exec_alu_a", 32'(alu_a), 32'(a));
    chk("op_exec_alu_b", 32'(alu_b), 32'(b));
    chk("op_exec_alu_op", 32'(alu_op), 32'(op));
    chk("op_exec_rv", 32'(resp_valid), 32'd0);
    chk("op_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("op_resp_valid", 32'(resp_valid), 32'd1);
    chk("op_resp_id", 32'(resp_id), 32'(id));
    chk("op_resp_result", 32'(resp_result), 32'(exp_res));
    chk("op_resp_flag", 32'(resp_flag), 32'(exp_flag));
    @(posedge clk);
    #1 exp_count = exp_count + 16'd1;
    chk("op_done_rv", 32'(resp_valid), 32'd0);
    chk("op_done_busy", 32'(busy), 32'd0);
    chk("op_done_count", 32'(op_count), 32'(exp_count));
  endtask

  // stimulus and scoreboard
  logic [7:0] xa[4];
  logic [7:0] exp_x[4];

  initial begin
    xa    = '{8'h3C, 8'h5A, 8'h0F, 8'hF0};
    exp_x = '{8'hC3, 8'hA5, 8'hF0, 8'h0F};

    // 1: reset state and first add
    do_reset();
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_resp_flag", 32'(resp_flag), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    run_op(0, 8'h0F, 8'h01, 2'b00, 8'h10, 1'b0);

    // 2: carry and borrow
    run_op(1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    run_op(1, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b1);

    // 3: all requesters contending
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, xa[i], 8'hFF, 2'b10);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      logic [3:0] oh;
      int g;
      g  = n % N;
      oh = 4'b0001 << g;
      #1 chk("rr_ready", 32'(req_ready), 32'(oh));
      @(posedge clk);
      #1 chk("rr_exec_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 chk("rr_resp_valid", 32'(resp_valid), 32'd1);
      chk("rr_resp_id", 32'(resp_id), 32'(g));
      chk("rr_resp_result", 32'(resp_result), 32'(exp_x[g]));
      chk("rr_resp_ready", 32'(req_ready), 32'd0);
      if (n == 4) req_valid = '0;
      @(posedge clk);
      #1 exp_count = exp_count + 16'd1;
      chk("rr_count", 32'(op_count), 32'(exp_count));
    end

    // 4: response backpressure with another request pending
    resp_ready = 1'b0;
    set_req(2, 8'h05, 8'h03, 2'b01);
    req_valid[2] = 1'b1;
    #1 chk("bp_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    set_req(3, 8'h81, 8'h01, 2'b11);
    req_valid[3] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_rv", 32'(resp_valid), 32'd1);
      chk("bp_result", 32'(resp_result), 32'h02);
      chk("bp_flag", 32'(resp_flag), 32'd0);
      chk("bp_id", 32'(resp_id), 32'd2);
      chk("bp_ready0", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_count", 32'(op_count), 32'(exp_count));
      @(posedge clk);
    end
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 exp_count = exp_count + 16'd1;
    chk("bp_done_count", 32'(op_count), 32'(exp_count));
    chk("bp_done_rv", 32'(resp_valid), 32'd0);
    chk("bp_next_ready", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    @(posedge clk);
    #1 chk("shl_result", 32'(resp_result), 32'h02);
    chk("shl_flag", 32'(resp_flag), 32'd0);
    chk("shl_id", 32'(resp_id), 32'd3);
    @(posedge clk);
    #1 exp_count = exp_count + 16'd1;
    chk("shl_count", 32'(op_count), 32'(exp_count));

    // 5: reset while executing
    set_req(1, 8'h12, 8'h34, 2'b00);
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 chk("mid_rst_rv", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_count = 16'd0;
    set_req(2, 8'h77, 8'h11, 2'b10);
    req_valid[2] = 1'b1;
    run_op(0, 8'h20, 8'h22, 2'b10, 8'h02, 1'b0);
    req_valid[2] = 1'b0;
    chk("post_rst_count", 32'(op_count), 32'd1);

    // 6: op_count wrap
    force dut.op_count_q = 16'hFFFF;
    #1 release dut.op_count_q;
    exp_count = 16'hFFFF;
    chk("wrap_pre", 32'(op_count), 32'hFFFF);
    run_op(3, 8'h40, 8'h40, 2'b00, 8'h80, 1'b0);
    chk("wrap_zero", 32'(op_count), 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
